// File: rtl/vdp_scroll_tile_fetcher.sv
// vdp_scroll_tile_fetcher: per-layer map/tile-row fetcher feeding a scroll pixel generator.
// Once per 8-pixel group it reads one map entry and two tile-row words over a req/ack
// VRAM port, then presents the row and palette with their load strobes.
// Optional feature macro: VDP_SCROLL_HFLIP_EN (horizontal flip via map bit 10).
module vdp_scroll_tile_fetcher #(
   parameter int unsigned MAP_WIDTH_LOG2  = 6,
   parameter int unsigned MAP_HEIGHT_LOG2 = 6
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        line_active,
   input  logic [10:0] raster_x,
   input  logic [9:0]  raster_y,
   input  logic [10:0] scroll_x,
   input  logic [10:0] scroll_y,
   input  logic [15:0] map_base,
   input  logic [15:0] tile_base,
   output logic [15:0] vram_addr,
   output logic        vram_read_req,
   input  logic        vram_read_ack,
   input  logic [15:0] vram_read_data,
   output logic [31:0] pixel_row,
   output logic [3:0]  palette_number,
   output logic        tile_row_load_enable,
   output logic        meta_load_enable,
   output logic        shifter_preload_load_enable,
   output logic        underrun
);

   typedef enum logic [2:0] {
      StIdle,
      StMapReq,
      StRow0Req,
      StRow1Req,
      StDone
   } state_e;

   localparam logic [15:0] XMask = 16'((1 << MAP_WIDTH_LOG2) - 1);
   localparam logic [15:0] YMask = 16'((1 << MAP_HEIGHT_LOG2) - 1);

   state_e      state_q, state_d;
   logic [15:0] addr_q, addr_d;
   logic [2:0]  yfine_q, yfine_d;
   logic [3:0]  palette_q, palette_d;
   logic [15:0] row_hi_q, row_hi_d;
   logic [31:0] pixel_row_q, pixel_row_d;
   logic        underrun_q, underrun_d;
`ifdef VDP_SCROLL_HFLIP_EN
   logic        hflip_q, hflip_d;
`endif

   logic [10:0] x_sum, y_sum;
   logic [5:0]  tile_x, tile_y;
   logic [15:0] map_addr, tile_addr;
   logic [2:0]  fine_y;
   logic [31:0] row_raw, row_new;
   logic        boundary, group_end;
   logic        ack_map, ack_row0, ack_row1;
   logic        underrun_now;

`ifdef VDP_SCROLL_HFLIP_EN
   function automatic logic [31:0] nibble_rev(input logic [31:0] r);
      logic [31:0] o;
      for (int i = 0; i < 8; i++) begin
         o[4*i +: 4] = r[4*(7-i) +: 4];
      end
      return o;
   endfunction
`endif

   // Fetch coordinates, map/tile addresses and handshake qualifiers.
   always_comb begin
      // Fetch targets the next group, hence the +8 lookahead.
      x_sum     = raster_x + 11'd8 + {2'b00, scroll_x[8:0]};
      y_sum     = {1'b0, raster_y} + {2'b00, scroll_y[8:0]};
      tile_x    = x_sum[8:3];
      tile_y    = y_sum[8:3];
      map_addr  = map_base + (((16'(tile_y) & YMask) << MAP_WIDTH_LOG2) | (16'(tile_x) & XMask));
      fine_y    = vram_read_data[11] ? ~yfine_q : yfine_q;
      tile_addr = tile_base + {2'b00, vram_read_data[9:0], fine_y, 1'b0};
      row_raw   = {row_hi_q, vram_read_data};
`ifdef VDP_SCROLL_HFLIP_EN
      row_new   = hflip_q ? nibble_rev(row_raw) : row_raw;
`else
      row_new   = row_raw;
`endif
      boundary  = (raster_x[2:0] == 3'd0);
      group_end = (raster_x[2:0] == 3'd7);
      ack_map   = (state_q == StMapReq)  && vram_read_ack;
      ack_row0  = (state_q == StRow0Req) && vram_read_ack;
      ack_row1  = (state_q == StRow1Req) && vram_read_ack;
      // Underrun is only meaningful on an active line; a last-cycle row ack still completes.
      underrun_now = line_active && group_end && (state_q != StDone) && !ack_row1;
   end

   // Next-state logic and data latching.
   always_comb begin
      state_d     = state_q;
      addr_d      = addr_q;
      yfine_d     = yfine_q;
      palette_d   = palette_q;
      row_hi_d    = row_hi_q;
      pixel_row_d = pixel_row_q;
      underrun_d  = underrun_q;
`ifdef VDP_SCROLL_HFLIP_EN
      hflip_d     = hflip_q;
`endif
      unique case (state_q)
         StIdle, StDone: begin
            if (boundary && line_active) begin
               state_d = StMapReq;
               addr_d  = map_addr;
               yfine_d = y_sum[2:0];
            end
         end
         StMapReq: begin
            if (vram_read_ack) begin
               state_d   = StRow0Req;
               addr_d    = tile_addr;
               palette_d = vram_read_data[15:12];
`ifdef VDP_SCROLL_HFLIP_EN
               hflip_d   = vram_read_data[10];
`endif
            end
         end
         StRow0Req: begin
            if (vram_read_ack) begin
               state_d  = StRow1Req;
               addr_d   = addr_q + 16'd1;
               row_hi_d = vram_read_data;
            end
         end
         StRow1Req: begin
            if (vram_read_ack) begin
               state_d     = StDone;
               pixel_row_d = row_new;
            end
         end
         default: state_d = StIdle;
      endcase

      if (underrun_now) begin
         state_d     = StIdle;
         pixel_row_d = 32'h0;
         palette_d   = 4'h0;
         underrun_d  = 1'b1;
      end
      if (boundary && !line_active) begin
         state_d = StIdle;
      end
   end

   // State and datapath registers.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= StIdle;
         addr_q      <= 16'h0;
         yfine_q     <= 3'h0;
         palette_q   <= 4'h0;
         row_hi_q    <= 16'h0;
         pixel_row_q <= 32'h0;
         underrun_q  <= 1'b0;
`ifdef VDP_SCROLL_HFLIP_EN
         hflip_q     <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         addr_q      <= addr_d;
         yfine_q     <= yfine_d;
         palette_q   <= palette_d;
         row_hi_q    <= row_hi_d;
         pixel_row_q <= pixel_row_d;
         underrun_q  <= underrun_d;
`ifdef VDP_SCROLL_HFLIP_EN
         hflip_q     <= hflip_d;
`endif
      end
   end

   // Outputs; latched data is bypassed on the ack cycle and blanked on underrun.
   always_comb begin
      vram_read_req  = (state_q == StMapReq) || (state_q == StRow0Req) ||
                       (state_q == StRow1Req);
      vram_addr      = vram_read_req ? addr_q : 16'h0;
      palette_number = underrun_now ? 4'h0 :
                       ack_map      ? vram_read_data[15:12] : palette_q;
      pixel_row      = underrun_now ? 32'h0 :
                       ack_row1     ? row_new : pixel_row_q;
      tile_row_load_enable        = ack_row1;
      meta_load_enable            = ack_map && !underrun_now;
      shifter_preload_load_enable = line_active && group_end;
      underrun                    = underrun_q;
   end

   logic unused_bits;
   assign unused_bits = ^{scroll_x[10:9], scroll_y[10:9], x_sum[10:9], x_sum[2:0],
                          y_sum[10:9], vram_read_data[10], ack_row0};

endmodule

// File: tb/tb_vdp_scroll_tile_fetcher.sv
// Scoreboard bench for vdp_scroll_tile_fetcher: directed groups push expected addresses,
// palettes and rows; a monitor pops and compares on each handshake or load strobe.
module tb_vdp_scroll_tile_fetcher;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        line_active = 1'b0;
   logic [10:0] raster_x = '0;
   logic [9:0]  raster_y = '0;
   logic [10:0] scroll_x = '0;
   logic [10:0] scroll_y = '0;
   logic [15:0] map_base = 16'h1000;
   logic [15:0] tile_base = 16'h4000;
   logic [15:0] vram_addr;
   logic        vram_read_req;
   logic        vram_read_ack = 1'b0;
   logic [15:0] vram_read_data = '0;
   logic [31:0] pixel_row;
   logic [3:0]  palette_number;
   logic        tile_row_load_enable;
   logic        meta_load_enable;
   logic        shifter_preload_load_enable;
   logic        underrun;

   int n_checks = 0;
   int n_fail   = 0;

   logic [15:0] exp_addr_q[$];
   logic [3:0]  exp_pal_q[$];
   logic [31:0] exp_row_q[$];

   logic [15:0] mem [logic [15:0]];
   int          dly [3];
   logic        ack_en = 1'b1;
   int          cnt = 0;
   int          idx = 0;

   vdp_scroll_tile_fetcher #(
      .MAP_WIDTH_LOG2 (6),
      .MAP_HEIGHT_LOG2(6)
   ) dut (
      .clk                        (clk),
      .reset_n                    (reset_n),
      .line_active                (line_active),
      .raster_x                   (raster_x),
      .raster_y                   (raster_y),
      .scroll_x                   (scroll_x),
      .scroll_y                   (scroll_y),
      .map_base                   (map_base),
      .tile_base                  (tile_base),
      .vram_addr                  (vram_addr),
      .vram_read_req              (vram_read_req),
      .vram_read_ack              (vram_read_ack),
      .vram_read_data             (vram_read_data),
      .pixel_row                  (pixel_row),
      .palette_number             (palette_number),
      .tile_row_load_enable       (tile_row_load_enable),
      .meta_load_enable           (meta_load_enable),
      .shifter_preload_load_enable(shifter_preload_load_enable),
      .underrun                   (underrun)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // VRAM responder: acks each request dly[idx] cycles after it is first seen.
   always @(negedge clk) begin
      if (!reset_n) begin
         vram_read_ack = 1'b0;
         cnt = 0;
         idx = 0;
      end else if (vram_read_ack) begin
         vram_read_ack = 1'b0;
         idx++;
         cnt = vram_read_req ? 1 : 0;
         if (!vram_read_req) idx = 0;
      end else if (vram_read_req && ack_en) begin
         if (cnt >= dly[idx > 2 ? 2 : idx]) begin
            vram_read_ack  = 1'b1;
            vram_read_data = mem.exists(vram_addr) ? mem[vram_addr] : 16'h0;
         end else begin
            cnt++;
         end
      end else begin
         cnt = 0;
         if (!vram_read_req) idx = 0;
      end
   end

   // Monitor: compares whenever the DUT completes a handshake or presents a load strobe.
   always begin
      @(posedge clk);
      #8;
      if (reset_n) begin
         if (vram_read_req && vram_read_ack) begin
            if (exp_addr_q.size() == 0) chk("unexpected_read", {16'h0, vram_addr}, 32'hFFFF_FFFF);
            else chk("vram_addr", {16'h0, vram_addr}, {16'h0, exp_addr_q.pop_front()});
         end
         if (meta_load_enable) begin
            if (exp_pal_q.size() == 0) chk("unexpected_meta", {28'h0, palette_number}, 32'hFFFF_FFFF);
            else chk("palette_number", {28'h0, palette_number}, {28'h0, exp_pal_q.pop_front()});
         end
         if (tile_row_load_enable) begin
            if (exp_row_q.size() == 0) chk("unexpected_row", pixel_row, 32'hFFFF_FFFF);
            else chk("pixel_row", pixel_row, exp_row_q.pop_front());
         end
      end
   end

   // One pixel clock: drive raster_x just after the edge, return at the sampling point.
   task automatic cyc(input int x);
      @(posedge clk);
      #1;
      raster_x = 11'(x);
      #7;
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_req"}, {31'h0, vram_read_req}, 32'h0);
      chk({tag, "_addr"}, {16'h0, vram_addr}, 32'h0);
      chk({tag, "_row"}, pixel_row, 32'h0);
      chk({tag, "_pal"}, {28'h0, palette_number}, 32'h0);
      chk({tag, "_strobes"}, {29'h0, tile_row_load_enable, meta_load_enable,
                               shifter_preload_load_enable}, 32'h0);
      chk({tag, "_underrun"}, {31'h0, underrun}, 32'h0);
   endtask

   task automatic push_fetch(input logic [15:0] a_map, input logic [15:0] a_tile,
                             input logic [3:0] pal, input logic [31:0] row);
      exp_addr_q.push_back(a_map);
      exp_addr_q.push_back(a_tile);
      exp_addr_q.push_back(a_tile + 16'd1);
      exp_pal_q.push_back(pal);
      exp_row_q.push_back(row);
   endtask

   logic [31:0] hflip_exp;

   initial begin
      mem[16'h1001] = 16'h3005; mem[16'h4050] = 16'h1234; mem[16'h4051] = 16'h5678;
      mem[16'h1002] = 16'h0801; mem[16'h4010] = 16'hABCD; mem[16'h4011] = 16'hEF01;
      mem[16'h1003] = 16'h0400; mem[16'h4000] = 16'h1234; mem[16'h4001] = 16'h5678;
      mem[16'h1004] = 16'h5007; mem[16'h4070] = 16'hCAFE; mem[16'h4071] = 16'hBEEF;
      mem[16'h1006] = 16'h2006; mem[16'h4060] = 16'h0F0F; mem[16'h4061] = 16'hF0F0;
      mem[16'h1008] = 16'h1009; mem[16'h4090] = 16'h1111; mem[16'h4091] = 16'h2222;
      dly = '{1, 1, 1};
`ifdef VDP_SCROLL_HFLIP_EN
      hflip_exp = 32'h8765_4321;
`else
      hflip_exp = 32'h1234_5678;
`endif

      // Reset state
      #12;
      chk_all_zero("reset");
      cyc(0);
      reset_n = 1'b1;
      cyc(0);

      // Basic fetch: tile (1,0), entry 0x3005
      line_active = 1'b1;
      push_fetch(16'h1001, 16'h4050, 4'h3, 32'h1234_5678);
      for (int x = 0; x < 8; x++) begin
         cyc(x);
         if (x == 6) chk("basic_no_preload_x6", {31'h0, shifter_preload_load_enable}, 32'h0);
      end
      chk("basic_preload_x7", {31'h0, shifter_preload_load_enable}, 32'h1);
      chk("basic_underrun", {31'h0, underrun}, 32'h0);
      chk("basic_row_held", pixel_row, 32'h1234_5678);
      chk("basic_pal_held", {28'h0, palette_number}, 32'h3);

      // Vflip with vertical scroll: yf = 7, fine_y = 0, tile 1
      raster_y = 10'd2;
      scroll_y = 11'd5;
      push_fetch(16'h1002, 16'h4010, 4'h0, 32'hABCD_EF01);
      for (int x = 8; x < 16; x++) cyc(x);

      // Hflip entry 0x0400
      raster_y = 10'd0;
      scroll_y = 11'd0;
      push_fetch(16'h1003, 16'h4000, 4'h0, hflip_exp);
      for (int x = 16; x < 24; x++) cyc(x);

      // Row1 ack lands exactly on the last cycle of the group
      dly = '{1, 2, 1};
      push_fetch(16'h1004, 16'h4070, 4'h5, 32'hCAFE_BEEF);
      for (int x = 24; x < 32; x++) cyc(x);
      chk("simul_row_at_x7", pixel_row, 32'hCAFE_BEEF);
      chk("simul_preload", {31'h0, shifter_preload_load_enable}, 32'h1);
      dly = '{1, 1, 1};

      // Underrun: no acks through the group
      ack_en = 1'b0;
      exp_addr_q.push_back(16'h1005);
      for (int x = 32; x < 39; x++) cyc(x);
      chk("simul_no_underrun", {31'h0, underrun}, 32'h0);
      chk("underrun_req_pending", {31'h0, vram_read_req}, 32'h1);
      cyc(39);
      chk("underrun_row_zero", pixel_row, 32'h0);
      chk("underrun_pal_zero", {28'h0, palette_number}, 32'h0);
      chk("underrun_preload", {31'h0, shifter_preload_load_enable}, 32'h1);
      void'(exp_addr_q.pop_back());
      ack_en = 1'b1;

      // Next group fetches normally; underrun stays sticky
      push_fetch(16'h1006, 16'h4060, 4'h2, 32'h0F0F_F0F0);
      cyc(40);
      chk("underrun_set", {31'h0, underrun}, 32'h1);
      chk("underrun_req_dropped", {31'h0, vram_read_req}, 32'h0);
      for (int x = 41; x < 48; x++) cyc(x);
      chk("underrun_sticky", {31'h0, underrun}, 32'h1);
      chk("recovery_row", pixel_row, 32'h0F0F_F0F0);

      // line_active low: no requests, no preload
      line_active = 1'b0;
      for (int x = 48; x < 56; x++) begin
         cyc(x);
         chk("inactive_no_req", {31'h0, vram_read_req}, 32'h0);
         chk("inactive_no_preload", {31'h0, shifter_preload_load_enable}, 32'h0);
      end

      // Reset while ROW0 request is outstanding
      line_active = 1'b1;
      dly = '{1, 5, 1};
      exp_addr_q.push_back(16'h1008);
      exp_pal_q.push_back(4'h1);
      for (int x = 56; x < 61; x++) cyc(x);
      chk("row0_req_before_reset", {31'h0, vram_read_req}, 32'h1);
      chk("row0_addr_before_reset", {16'h0, vram_addr}, 32'h4090);
      line_active = 1'b0;
      reset_n = 1'b0;
      #1;
      chk_all_zero("midreset");
      cyc(61);
      chk_all_zero("held_reset");
      reset_n = 1'b1;
      cyc(62);

      chk("leftover_addr", exp_addr_q.size(), 32'd0);
      chk("leftover_pal", exp_pal_q.size(), 32'd0);
      chk("leftover_row", exp_row_q.size(), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/vdp_scroll_tile_fetcher.md
Name: vdp_scroll_tile_fetcher

Overview:
Upstream feeder for one scroll layer's pixel generator. Once per 8-pixel tile group it reads one map entry and one 32-bit tile row (two 16-bit words) from VRAM over a req/ack port. It presents the row and palette together with the three load strobes the pixel generator consumes: tile_row_load_enable, meta_load_enable and shifter_preload_load_enable. One instance exists per scroll layer; the VRAM arbiter sits behind the req/ack port.

Parameters:
MAP_WIDTH_LOG2, 6, map width in tiles as log2 (64 tiles = 512 px plane)
MAP_HEIGHT_LOG2, 6, map height in tiles as log2

Ports:
clk  in  1  pixel clock
reset_n  in  1  asynchronous active-low reset
line_active  in  1  high while the current line is fetched; low forces IDLE at the next group boundary
raster_x  in  11  current raster column
raster_y  in  10  current raster line
scroll_x  in  11  horizontal scroll; only [8:0] used
scroll_y  in  11  vertical scroll; only [8:0] used
map_base  in  16  VRAM word address of map
tile_base  in  16  VRAM word address of tile data
vram_addr  out  16  read address
vram_read_req  out  1  read request
vram_read_ack  in  1  one-cycle; data valid same cycle
vram_read_data  in  16  read data
pixel_row  out  32  fetched row; [31:28] = leftmost pixel
palette_number  out  4  palette of fetched tile
tile_row_load_enable  out  1  pulse: pixel_row valid
meta_load_enable  out  1  pulse: palette_number valid
shifter_preload_load_enable  out  1  pulse: preload into shifter
underrun  out  1  sticky: a group ended before its fetch completed

Behaviour:
- Clock and reset: single clock clk. reset_n is asynchronous and active-low.
- Reset values: all outputs 0, state IDLE.
- Group boundary: a group boundary is raster_x[2:0]==0.
  - At the boundary with line_active=1 the FSM leaves IDLE or DONE for MAP_REQ.
  - With line_active=0 the FSM goes to IDLE and issues no requests.
- Fetch coordinates:
  - xf = (raster_x + 8 + scroll_x) mod 512.
  - yf = (raster_y + scroll_y) mod 512.
  - tile_x = xf[8:3], tile_y = yf[8:3]. Both are truncated to the map size given by the parameters.
- Map address: vram_addr = map_base + {tile_y, tile_x}, mod 2^16.
- Map entry layout: [9:0] tile index, [10] hflip, [11] vflip, [15:12] palette.
- fine_y = vflip ? ~yf[2:0] : yf[2:0].
- Tile word address: tile_base + {index, fine_y, w}, mod 2^16. w=0 selects the high half (pixels 0-3), w=1 the low half.
- FSM states: IDLE, MAP_REQ, ROW0_REQ, ROW1_REQ, DONE.
  - vram_read_req is high in every *_REQ state, and vram_addr is held stable there.
  - Each *_REQ state advances on the cycle of vram_read_ack. The ack cycle latches data.
  - Ack is ignored in IDLE and DONE.
- Latch behaviour:
  - The map ack latches palette_number and pulses meta_load_enable for 1 cycle.
  - The ROW1 ack pulses tile_row_load_enable for 1 cycle. pixel_row is valid from that cycle.
- shifter_preload_load_enable: 1-cycle pulse when raster_x[2:0]==7 and line_active=1. It fires regardless of FSM state.
- Underrun: at raster_x[2:0]==7, if the state is not DONE:
  - pixel_row and palette_number are forced to 0 (transparent) in that same cycle;
  - underrun is set and stays set until reset;
  - the FSM aborts to IDLE and drops the request.
- Simultaneous ack and raster_x[2:0]==7 in ROW1_REQ: the ack wins. Row is latched, no underrun, the preload pulse still fires.
- Reset mid-request: vram_read_req drops immediately (asynchronous reset).

Optional Feature:
VDP_SCROLL_HFLIP_EN
- Defined: when map bit 10 is set, the nibble order of the 32-bit row is reversed before latching. Pixel 0 ↔ 7, 1 ↔ 6, etc.
- Undefined: bit 10 is ignored and the row is latched unflipped.

Test Plan:
- Basic fetch:
  - Stimulus: scroll 0, raster_y=0, line_active=1, raster_x 0..7, ack on the cycle after each req. Map entry 0x3005 at map_base=0x1000. Tile words 0x1234 / 0x5678. tile_base=0x4000.
  - Required response: addresses 0x1001, 0x4050, 0x4051 in that order. palette_number=3, pixel_row=0x12345678. Preload pulse at x=7. underrun=0.
- Vflip and scroll:
  - Stimulus: scroll_y=5, raster_y=2, entry 0x0801.
  - Required response: fine_y = ~7 = 0. Tile address = tile_base + 0x10.
- Hflip:
  - Stimulus: VDP_SCROLL_HFLIP_EN defined, entry 0x0400, row 0x12345678.
  - Required response: pixel_row=0x87654321. With the macro undefined the row stays 0x12345678.
- Underrun:
  - Stimulus: hold ack low through the group.
  - Required response: at x=7 pixel_row=0, palette_number=0, underrun=1 and stays 1. The next group fetches normally.
- Simultaneous ack and boundary:
  - Stimulus: ROW1 ack arrives exactly at x=7.
  - Required response: row latched, underrun stays 0.
- line_active low and reset:
  - Stimulus: line_active=0.
  - Required response: no req, no preload pulse.
  - Stimulus: assert reset_n=0 mid ROW0_REQ.
  - Required response: req drops immediately and all outputs go to 0.
